// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush and an optional
// two-entry skid buffer. Control bits are forced to zero whenever no entry is presented.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 3,
    parameter int SKID   = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [1:0]        occ_o
);

    logic              mainValid;
    logic [DATA_W-1:0] mainData;
    logic [CTRL_W-1:0] mainCtrl;
    logic              push;
    logic              pop;

    assign push    = valid_i & ready_o;
    assign pop     = mainValid & ready_i;
    assign valid_o = mainValid;
    assign data_o  = mainData;
    assign ctrl_o  = mainValid ? mainCtrl : '0;

    generate
        if (SKID != 0) begin : gSkid
            logic              skidValid;
            logic [DATA_W-1:0] skidData;
            logic [CTRL_W-1:0] skidCtrl;

            // The skid entry only exists behind a valid head, so it alone decides readiness.
            assign ready_o = ~skidValid;
            assign occ_o   = {1'b0, mainValid} + {1'b0, skidValid};

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    mainValid <= 1'b0;
                    mainData  <= '0;
                    mainCtrl  <= '0;
                    skidValid <= 1'b0;
                    skidData  <= '0;
                    skidCtrl  <= '0;
                end else if (flush_i) begin
                    mainValid <= 1'b0;
                    skidValid <= 1'b0;
                end else if (!mainValid) begin
                    if (push) begin
                        mainValid <= 1'b1;
                        mainData  <= data_i;
                        mainCtrl  <= ctrl_i;
                    end
                end else if (!skidValid) begin
                    if (push && pop) begin
                        mainData <= data_i;
                        mainCtrl <= ctrl_i;
                    end else if (push) begin
                        skidValid <= 1'b1;
                        skidData  <= data_i;
                        skidCtrl  <= ctrl_i;
                    end else if (pop) begin
                        mainValid <= 1'b0;
                    end
                end else if (pop) begin
                    mainData  <= skidData;
                    mainCtrl  <= skidCtrl;
                    skidValid <= 1'b0;
                end
            end
        end else begin : gSingle
            assign ready_o = ~mainValid | ready_i;
            assign occ_o   = {1'b0, mainValid};

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    mainValid <= 1'b0;
                    mainData  <= '0;
                    mainCtrl  <= '0;
                end else if (flush_i) begin
                    mainValid <= 1'b0;
                end else if (push) begin
                    mainValid <= 1'b1;
                    mainData  <= data_i;
                    mainCtrl  <= ctrl_i;
                end else if (pop) begin
                    mainValid <= 1'b0;
                end
            end
        end
    endgenerate

endmodule
